// File: rtl/icache.sv
// Direct-mapped instruction cache: SETS single-word frames, one outstanding
// fill at a time. Hit is combinational in IDLE; a miss spends memory latency
// plus one cycle in FETCH and hits on the cycle after the fill.
// Ports: CLK/nRST (async active-low); imemREN/imemaddr/ihit/imemload face the
// fetch stage; iREN/iaddr/iwait/iload face memory; flush invalidates all frames.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t state, next_state;

  logic          valid [SETS];
  logic [TW-1:0] tag   [SETS];
  logic [31:0]   data  [SETS];

  logic [IW-1:0] index;
  logic [TW-1:0] req_tag;
  logic          hit;
  logic          fill;
  logic          unused_offset;

  assign index         = imemaddr[IW+1:2];
  assign req_tag       = imemaddr[31:IW+2];
  assign unused_offset = ^imemaddr[1:0];

  // flush suppresses the hit so a requester never consumes a line that is
  // being invalidated on this very edge.
  assign hit  = (state == IDLE) && imemREN && !flush &&
                valid[index] && (tag[index] == req_tag);

  // A fill completes only while the request is still present; flush wins.
  assign fill = (state == FETCH) && imemREN && !iwait && !flush;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (imemREN && !hit) next_state = FETCH;
      FETCH:   if (!imemREN || !iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'd0;
    iREN     = 1'b0;
    iaddr    = 32'd0;
    case (state)
      IDLE: begin
        ihit     = hit;
        imemload = hit ? data[index] : 32'd0;
      end
      FETCH: begin
        iREN  = imemREN && !flush;
        iaddr = {imemaddr[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Frame storage
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        valid[i] <= 1'b0;
        tag[i]   <= '0;
        data[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < SETS; i++) begin
        valid[i] <= 1'b0;
      end
    end else if (fill) begin
      valid[index] <= 1'b1;
      tag[index]   <= req_tag;
      data[index]  <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;

  int checks;
  int errors;

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .flush    (flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge and
  // outputs are checked mid-cycle, well away from either edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Complete miss/fill on addr with nwait busy cycles, then verify the hit.
  task automatic do_fill(input string tag, input logic [31:0] addr,
                         input logic [31:0] word, input int nwait);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1; iload = 32'hDEAD_BEEF;
    settle();
    check({tag, "_miss"}, {31'd0, ihit}, 32'd0);
    check({tag, "_miss_iren"}, {31'd0, iREN}, 32'd0);
    step();
    for (int i = 0; i < nwait; i++) begin
      settle();
      check({tag, "_wait_iren"}, {31'd0, iREN}, 32'd1);
      step();
    end
    iwait = 1'b0; iload = word;
    settle();
    check({tag, "_fetch_iren"}, {31'd0, iREN}, 32'd1);
    check({tag, "_fetch_iaddr"}, iaddr, {addr[31:2], 2'b00});
    check({tag, "_fetch_ihit"}, {31'd0, ihit}, 32'd0);
    step();
    iwait = 1'b1; iload = 32'hDEAD_BEEF;
    settle();
    check({tag, "_hit"}, {31'd0, ihit}, 32'd1);
    check({tag, "_load"}, imemload, word);
    check({tag, "_hit_iren"}, {31'd0, iREN}, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1;
    iload = 32'd0; flush = 1'b0;

    // Reset state
    #3;
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check("rst_load", imemload, 32'd0);
    check("rst_iren", {31'd0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    step();
    nRST = 1'b1;
    step();

    // Cold miss: two busy cycles then data
    do_fill("cold", 32'h0000_0040, 32'h2001_0005, 2);

    // Repeat hit, and byte offset bits ignored
    step();
    settle();
    check("rehit", {31'd0, ihit}, 32'd1);
    check("rehit_iren", {31'd0, iREN}, 32'd0);
    imemaddr = 32'h0000_0043;
    settle();
    check("offset_hit", {31'd0, ihit}, 32'd1);
    check("offset_load", imemload, 32'h2001_0005);
    step();

    // Conflict: 0x80 maps to index 0 with a different tag
    do_fill("conf", 32'h0000_0080, 32'hAAAA_0080, 0);
    step();
    imemaddr = 32'h0000_0040;
    settle();
    check("conf_evict", {31'd0, ihit}, 32'd0);
    check("conf_evict_load", imemload, 32'd0);
    step();
    imemREN = 1'b0;
    step();
    do_fill("refill", 32'h0000_0040, 32'h1111_2222, 1);
    step();

    // Flush on the same edge as a fill of 0x44
    imemREN = 1'b1; imemaddr = 32'h0000_0044; iwait = 1'b1;
    step();
    iwait = 1'b0; iload = 32'h4444_4444; flush = 1'b1;
    settle();
    check("flush_iren", {31'd0, iREN}, 32'd0);
    check("flush_ihit", {31'd0, ihit}, 32'd0);
    step();
    flush = 1'b0; iwait = 1'b1;
    settle();
    check("postflush_miss", {31'd0, ihit}, 32'd0);
    step();
    settle();
    check("postflush_iren", {31'd0, iREN}, 32'd1);
    check("postflush_iaddr", iaddr, 32'h0000_0044);
    imemaddr = 32'h0000_0040;
    settle();
    check("flush_cleared_40", {31'd0, ihit}, 32'd0);
    imemREN = 1'b0;
    step();

    // Abort: drop request during FETCH
    imemREN = 1'b1; imemaddr = 32'h0000_0100; iwait = 1'b1;
    step();
    settle();
    check("abort_fetch_iren", {31'd0, iREN}, 32'd1);
    imemREN = 1'b0; iwait = 1'b0; iload = 32'h0BAD_0100;
    settle();
    check("abort_drop_iren", {31'd0, iREN}, 32'd0);
    step();
    iwait = 1'b1;
    settle();
    check("abort_idle_iren", {31'd0, iREN}, 32'd0);
    check("abort_idle_iaddr", iaddr, 32'd0);
    imemREN = 1'b1;
    settle();
    check("abort_still_miss", {31'd0, ihit}, 32'd0);
    step();
    imemREN = 1'b0;
    step();

    // Reset mid-fetch
    do_fill("pre_rst", 32'h0000_0048, 32'h4848_4848, 0);
    step();
    imemaddr = 32'h0000_0200; iwait = 1'b1;
    step();
    settle();
    check("rstfetch_iren", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    check("rstfetch_iren_drop", {31'd0, iREN}, 32'd0);
    check("rstfetch_ihit", {31'd0, ihit}, 32'd0);
    step();
    nRST = 1'b1;
    imemaddr = 32'h0000_0048;
    settle();
    check("rst_lost_hit", {31'd0, ihit}, 32'd0);
    check("rst_lost_load", imemload, 32'd0);
    imemREN = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
